step_pulse_gen: RTL and testbench

- Input-conditioning stage that drives the 4-bit step counter's clock input.
- Takes a raw asynchronous push-button and produces clean, fixed-width step pulses. The counter advances on the falling edge of each pulse.
- Synchronises and debounces the button, and emits one pulse per press. Optional auto-repeat while the button is held.
- Keeps a running total of emitted pulses for display and debug.

---
 rtl/step_pulse_gen.sv | 156 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: conditions a raw push-button into fixed-width step pulses
// for the step counter's clock input, with optional auto-repeat while held.
//
// Ports:
//   clockStep      - system clock, all logic on the rising edge
//   resetStep      - synchronous active-low reset
//   buttonStep     - raw asynchronous button, active-high
//   repeatEnStep   - auto-repeat enable, sampled at the end of each pulse
//   stepPulse      - registered step pulse, PULSE_WIDTH cycles high
//   busyStep       - registered, high whenever the FSM is not idle
//   pulseTotalStep - running count of emitted pulses, wraps at 256
module step_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_WIDTH     = 2,
   parameter int unsigned HOLD_DELAY      = 64,
   parameter int unsigned REPEAT_PERIOD   = 16,
   parameter int unsigned TIMER_W         = 8
) (
   input  logic       clockStep,
   input  logic       resetStep,
   input  logic       buttonStep,
   input  logic       repeatEnStep,
   output logic       stepPulse,
   output logic       busyStep,
   output logic [7:0] pulseTotalStep
);

   localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] PW_LAST   = TIMER_W'(PULSE_WIDTH);
   localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_DELAY - 1);
   localparam logic [TIMER_W-1:0] REP_LAST  = TIMER_W'(REPEAT_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEB_PRESS,
      S_PULSE,
      S_HOLD,
      S_WAIT_REL,
      S_DEB_REL
   } state_e;

   state_e               state_q;
   logic                 sync1_q;
   logic                 sync2_q;
   logic [TIMER_W-1:0]   timer_q;
   logic                 repeat_q;   // last pulse was a repeat pulse
   logic                 pulse_q;
   logic                 busy_q;
   logic [7:0]           total_q;
   logic                 btn_s;
   logic [TIMER_W-1:0]   hold_last;

   assign btn_s     = sync2_q;
   // First gap of a press is the long hold delay, later gaps the repeat period.
   assign hold_last = repeat_q ? REP_LAST : HOLD_LAST;

   assign stepPulse      = pulse_q;
   assign busyStep       = busy_q;
   assign pulseTotalStep = total_q;

   // Synchroniser, debounce/repeat FSM and registered outputs.
   always_ff @(posedge clockStep) begin
      if (!resetStep) begin
         state_q  <= S_IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         timer_q  <= '0;
         repeat_q <= 1'b0;
         pulse_q  <= 1'b0;
         busy_q   <= 1'b0;
         total_q  <= 8'd0;
      end else begin
         sync1_q <= buttonStep;
         sync2_q <= sync1_q;
         busy_q  <= 1'b1;   // overridden on every transition into IDLE
         case (state_q)
            S_IDLE: begin
               if (btn_s) begin
                  state_q <= S_DEB_PRESS;
                  timer_q <= T_ONE;
               end else begin
                  timer_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            S_DEB_PRESS: begin
               if (!btn_s) begin
                  state_q <= S_IDLE;
                  timer_q <= '0;
                  busy_q  <= 1'b0;
               end else if (timer_q >= DEB_LAST) begin
                  state_q  <= S_PULSE;
                  timer_q  <= T_ONE;
                  pulse_q  <= 1'b1;
                  total_q  <= total_q + 8'd1;
                  repeat_q <= 1'b0;
               end else begin
                  timer_q <= timer_q + T_ONE;
               end
            end
            S_PULSE: begin
               // Button is ignored until the pulse completes its full width.
               if (timer_q >= PW_LAST) begin
                  pulse_q <= 1'b0;
                  timer_q <= '0;
                  if (!btn_s)            state_q <= S_DEB_REL;
                  else if (repeatEnStep) state_q <= S_HOLD;
                  else                   state_q <= S_WAIT_REL;
               end else begin
                  timer_q <= timer_q + T_ONE;
               end
            end
            S_HOLD: begin
               if (!btn_s) begin
                  state_q <= S_DEB_REL;
                  timer_q <= T_ONE;
               end else if (timer_q >= hold_last) begin
                  state_q  <= S_PULSE;
                  timer_q  <= T_ONE;
                  pulse_q  <= 1'b1;
                  total_q  <= total_q + 8'd1;
                  repeat_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + T_ONE;
               end
            end
            S_WAIT_REL: begin
               if (!btn_s) begin
                  state_q <= S_DEB_REL;
                  timer_q <= T_ONE;
               end
            end
            S_DEB_REL: begin
               // Timer counts consecutive low samples; any high sample restarts it.
               if (btn_s) begin
                  timer_q <= '0;
               end else if (timer_q >= DEB_LAST) begin
                  state_q <= S_IDLE;
                  timer_q <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q + T_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               timer_q <= '0;
               pulse_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: directed scenarios plus randomized presses
// checked against an arithmetic model of pulse timing.
module tb_step_pulse_gen;

   localparam int DEB  = 16;
   localparam int PW   = 2;
   localparam int HOLD = 64;
   localparam int REP  = 16;

   logic       clockStep = 1'b0;
   logic       resetStep;
   logic       buttonStep;
   logic       repeatEnStep;
   logic       stepPulse;
   logic       busyStep;
   logic [7:0] pulseTotalStep;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;
   int run_len = 0;
   logic prev_pulse = 1'b0;
   int rise_q[$];
   int width_q[$];
   int exp_q[$];
   int exp_total = 0;

   step_pulse_gen dut (
      .clockStep      (clockStep),
      .resetStep      (resetStep),
      .buttonStep     (buttonStep),
      .repeatEnStep   (repeatEnStep),
      .stepPulse      (stepPulse),
      .busyStep       (busyStep),
      .pulseTotalStep (pulseTotalStep)
   );

   always #5 clockStep = ~clockStep;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock, sample just after the edge and log pulse rises/widths.
   task automatic tick();
      @(posedge clockStep);
      #1;
      edge_n++;
      if (stepPulse === 1'b1 && prev_pulse !== 1'b1) rise_q.push_back(edge_n);
      if (stepPulse === 1'b1) run_len++;
      else if (prev_pulse === 1'b1) begin
         width_q.push_back(run_len);
         run_len = 0;
      end
      prev_pulse = stepPulse;
   endtask

   task automatic clear_logs();
      rise_q.delete();
      width_q.delete();
      exp_q.delete();
      run_len = 0;
   endtask

   // Hold the button h cycles, then release for gap cycles.
   task automatic press(input int h, input int gap, input bit rep);
      repeatEnStep = rep;
      buttonStep   = 1'b1;
      repeat (h) tick();
      buttonStep = 1'b0;
      repeat (gap) tick();
   endtask

   // Expected rise edges (relative to press start) for a clean press of h cycles.
   // The filtered button is high on edges 3..h+2; a pulse rises only on a high sample.
   task automatic model_press(input int h, input bit rep, input int base);
      int t;
      int last_hi;
      last_hi = h + 2;
      t = DEB + 2;
      if (t <= last_hi) begin
         exp_q.push_back(base + t);
         if (rep) begin
            t = t + PW + HOLD;
            while (t <= last_hi) begin
               exp_q.push_back(base + t);
               t = t + PW + REP;
            end
         end
      end
   endtask

   task automatic test_reset();
      int base;
      resetStep = 1'b0;
      buttonStep = 1'b1;
      repeatEnStep = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (stepPulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulse cyc%0d: got %b want 0", i, stepPulse);
         end
         n_tests++;
         if (busyStep !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, busyStep);
         end
         n_tests++;
         if (pulseTotalStep !== 8'd0) begin
            n_fail++; $display("FAIL reset_total cyc%0d: got %0d want 0", i, pulseTotalStep);
         end
      end
      clear_logs();
      base = edge_n;
      resetStep = 1'b1;
      repeat (25) tick();
      n_tests++;
      if (rise_q.size() != 1 || rise_q[0] != base + 18) begin
         n_fail++;
         $display("FAIL reset_latency: got %0d rises first at %0d want 1 at %0d",
                  rise_q.size(), (rise_q.size() > 0) ? rise_q[0] - base : -1, 18);
      end
      buttonStep = 1'b0;
      repeat (50) tick();
      exp_total = 1;
      n_tests++;
      if (busyStep !== 1'b0 || pulseTotalStep !== 8'(exp_total)) begin
         n_fail++;
         $display("FAIL reset_after: busy %b total %0d want busy 0 total %0d",
                  busyStep, pulseTotalStep, exp_total);
      end
   endtask

   task automatic test_bounce();
      clear_logs();
      press(10, 40, 1'b0);
      n_tests++;
      if (rise_q.size() != 0) begin
         n_fail++; $display("FAIL bounce_pulses: got %0d want 0", rise_q.size());
      end
      n_tests++;
      if (pulseTotalStep !== 8'(exp_total)) begin
         n_fail++; $display("FAIL bounce_total: got %0d want %0d", pulseTotalStep, exp_total);
      end
      n_tests++;
      if (busyStep !== 1'b0) begin
         n_fail++; $display("FAIL bounce_busy: got %b want 0", busyStep);
      end
   endtask

   task automatic test_single();
      int base;
      clear_logs();
      base = edge_n;
      press(100, 40, 1'b0);
      exp_total++;
      n_tests++;
      if (rise_q.size() != 1 || rise_q[0] != base + 18) begin
         n_fail++;
         $display("FAIL single_rise: got %0d rises first at %0d want 1 at 18",
                  rise_q.size(), (rise_q.size() > 0) ? rise_q[0] - base : -1);
      end
      n_tests++;
      if (width_q.size() != 1 || width_q[0] != PW) begin
         n_fail++;
         $display("FAIL single_width: got %0d widths first %0d want 1 of %0d",
                  width_q.size(), (width_q.size() > 0) ? width_q[0] : -1, PW);
      end
      n_tests++;
      if (pulseTotalStep !== 8'(exp_total) || busyStep !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end: total %0d busy %b want total %0d busy 0",
                  pulseTotalStep, busyStep, exp_total);
      end
   endtask

   task automatic test_repeat();
      int base;
      clear_logs();
      base = edge_n;
      model_press(300, 1'b1, base);
      press(300, 60, 1'b1);
      exp_total += exp_q.size();
      n_tests++;
      if (rise_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL repeat_count: got %0d want %0d", rise_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (rise_q[i] != exp_q[i]) begin
               n_fail++;
               $display("FAIL repeat_rise%0d: got edge %0d want %0d", i, rise_q[i] - base, exp_q[i] - base);
            end
         end
      end
      foreach (width_q[i]) begin
         n_tests++;
         if (width_q[i] != PW) begin
            n_fail++; $display("FAIL repeat_width%0d: got %0d want %0d", i, width_q[i], PW);
         end
      end
      n_tests++;
      if (pulseTotalStep !== 8'(exp_total)) begin
         n_fail++; $display("FAIL repeat_total: got %0d want %0d", pulseTotalStep, exp_total);
      end
   endtask

   task automatic test_release_bounce();
      int r;
      clear_logs();
      repeatEnStep = 1'b0;
      buttonStep = 1'b1;
      repeat (30) tick();
      for (int i = 0; i < 10; i++) begin
         buttonStep = (i % 2 == 1);
         repeat (3) tick();
      end
      buttonStep = 1'b0;
      r = edge_n + 1;
      repeat (17) tick();
      n_tests++;
      if (busyStep !== 1'b1) begin
         n_fail++; $display("FAIL relbounce_busy_early edge r+%0d: got %b want 1", edge_n - r, busyStep);
      end
      tick();
      n_tests++;
      if (busyStep !== 1'b0) begin
         n_fail++; $display("FAIL relbounce_idle edge r+%0d: got %b want 0", edge_n - r, busyStep);
      end
      exp_total++;
      n_tests++;
      if (rise_q.size() != 1 || pulseTotalStep !== 8'(exp_total)) begin
         n_fail++;
         $display("FAIL relbounce_pulses: rises %0d total %0d want 1 and %0d",
                  rise_q.size(), pulseTotalStep, exp_total);
      end
      repeat (10) tick();
   endtask

   task automatic test_reset_mid_pulse();
      bit seen;
      clear_logs();
      seen = 1'b0;
      repeatEnStep = 1'b0;
      buttonStep = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (stepPulse === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin
         n_fail++; $display("FAIL midreset_wait: got no pulse want pulse within 40 cycles");
      end
      resetStep = 1'b0;
      tick();
      n_tests++;
      if (stepPulse !== 1'b0 || pulseTotalStep !== 8'd0 || busyStep !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clear: pulse %b total %0d busy %b want 0 0 0",
                  stepPulse, pulseTotalStep, busyStep);
      end
      exp_total = 0;
      resetStep = 1'b1;
      buttonStep = 1'b0;
      repeat (30) tick();
      n_tests++;
      if (pulseTotalStep !== 8'd0 || busyStep !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_after: total %0d busy %b want 0 0", pulseTotalStep, busyStep);
      end
   endtask

   task automatic test_wrap();
      bit checked;
      clear_logs();
      checked = 1'b0;
      repeatEnStep = 1'b1;
      buttonStep = 1'b1;
      for (int i = 0; i < 6000 && rise_q.size() < 256; i++) begin
         tick();
         if (rise_q.size() == 255 && !checked) begin
            checked = 1'b1;
            n_tests++;
            if (pulseTotalStep !== 8'd255) begin
               n_fail++; $display("FAIL wrap_255: got %0d want 255", pulseTotalStep);
            end
         end
      end
      buttonStep = 1'b0;
      repeat (60) tick();
      n_tests++;
      if (rise_q.size() != 256) begin
         n_fail++; $display("FAIL wrap_count: got %0d want 256", rise_q.size());
      end
      n_tests++;
      if (pulseTotalStep !== 8'd0 || busyStep !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_total: total %0d busy %b want 0 0", pulseTotalStep, busyStep);
      end
      exp_total = 0;
   endtask

   task automatic test_random();
      int base;
      int h;
      bit rep;
      for (int k = 0; k < 10; k++) begin
         clear_logs();
         if (k == 0)      begin h = 15; rep = 1'b0; end
         else if (k == 1) begin h = 16; rep = 1'b0; end
         else begin
            h   = int'($urandom_range(1, 260));
            rep = 1'($urandom_range(0, 1));
         end
         base = edge_n;
         model_press(h, rep, base);
         press(h, 50, rep);
         exp_total = (exp_total + exp_q.size()) % 256;
         n_tests++;
         if (rise_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand%0d_count h=%0d rep=%0d: got %0d want %0d",
                     k, h, rep, rise_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               n_tests++;
               if (rise_q[i] != exp_q[i]) begin
                  n_fail++;
                  $display("FAIL rand%0d_rise%0d: got edge %0d want %0d",
                           k, i, rise_q[i] - base, exp_q[i] - base);
               end
            end
         end
         foreach (width_q[i]) begin
            n_tests++;
            if (width_q[i] != PW) begin
               n_fail++; $display("FAIL rand%0d_width%0d: got %0d want %0d", k, i, width_q[i], PW);
            end
         end
         n_tests++;
         if (pulseTotalStep !== 8'(exp_total) || busyStep !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_end: total %0d busy %b want total %0d busy 0",
                     k, pulseTotalStep, busyStep, exp_total);
         end
      end
   endtask

   initial begin
      resetStep    = 1'b0;
      buttonStep   = 1'b0;
      repeatEnStep = 1'b0;
      test_reset();
      test_bounce();
      test_single();
      test_repeat();
      test_release_bounce();
      test_reset_mid_pulse();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
